// File: rtl/note_sequencer.sv
// Note recorder/player: records {octave,note} words into a small register array
// and plays them back one per tempo step, optionally looping.
module note_sequencer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned OCT_W  = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [NOTE_W-1:0] note_data,
  input  logic [OCT_W-1:0]  octave_data,
  input  logic              ld_note,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              loop_en,
  input  logic              step_pulse,
  output logic [NOTE_W-1:0] note_out,
  output logic [OCT_W-1:0]  octave_out,
  output logic              note_valid,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              playing,
  output logic              overflow,
  output logic              done
);

  localparam int unsigned WW = OCT_W + NOTE_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ld_q;
  logic [WW-1:0]   word_q, word_d;
  logic            overflow_q, overflow_d;
  logic [WW-1:0]   mem_q [DEPTH];

  logic            rec_event;
  logic            is_full;
  logic            at_last;
  logic            wr_en;
  logic [CW-1:0]   count_m1;

  assign rec_event = ld_note & ~ld_q;
  assign is_full   = (count_q == CW'(DEPTH));
  assign count_m1  = count_q - CW'(1);
  assign at_last   = ({1'b0, rd_ptr_q} == count_m1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    word_d     = word_q;
    overflow_d = 1'b0;
    wr_en      = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
      word_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A start request on a non-empty sequence swallows a coincident record edge.
          if (play_start && (count_q != '0)) begin
            rd_ptr_d = '0;
            state_d  = FETCH;
          end else if (rec_event) begin
            if (is_full) begin
              overflow_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
        end
        FETCH: begin
          if (play_stop) begin
            state_d = IDLE;
          end else begin
            word_d  = mem_q[rd_ptr_q];
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (play_stop) begin
            state_d = IDLE;
          end else if (step_pulse) begin
            if (!at_last) begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              state_d  = FETCH;
            end else if (loop_en) begin
              rd_ptr_d = '0;
              state_d  = FETCH;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      ld_q       <= 1'b0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      ld_q       <= ld_note;
      word_q     <= word_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[count_q[AW-1:0]] <= {octave_data, note_data};
    end
  end

  assign note_out   = word_q[NOTE_W-1:0];
  assign octave_out = word_q[NOTE_W +: OCT_W];
  assign note_valid = (state_q == HOLD);
  assign playing    = (state_q == FETCH) || (state_q == HOLD);
  // An abort arriving in the DONE cycle suppresses the completion pulse.
  assign done       = (state_q == DONE) && !play_stop && !clear;
  assign overflow   = overflow_q;
  assign count      = count_q;
  assign full       = is_full;
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a queue-based model predicts every
// presented note, done pulse and overflow pulse; a forked monitor consumes them.
module tb_note_sequencer;
  localparam int DEPTH = 16;
  localparam logic [1:0] K_NOTE = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_OVF  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [5:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] note_data = '0;
  logic [1:0] octave_data = '0;
  logic       ld_note = 1'b0;
  logic       play_start = 1'b0;
  logic       play_stop = 1'b0;
  logic       loop_en = 1'b0;
  logic       step_pulse = 1'b0;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic       note_valid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       playing;
  logic       overflow;
  logic       done;

  note_sequencer #(.DEPTH(DEPTH), .NOTE_W(4), .OCT_W(2)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .note_data(note_data), .octave_data(octave_data), .ld_note(ld_note),
    .play_start(play_start), .play_stop(play_stop), .loop_en(loop_en),
    .step_pulse(step_pulse), .note_out(note_out), .octave_out(octave_out),
    .note_valid(note_valid), .count(count), .full(full), .empty(empty),
    .playing(playing), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [5:0] rec_q[$];
  int   ptr = 0;
  bit   m_play = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void pop_cmp(logic [1:0] kind, logic [5:0] word);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_unexpected actual_kind=%0d expected=none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("scoreboard_kind", 32'(kind), 32'(e.kind));
      if (e.kind == K_NOTE && kind == K_NOTE) chk("scoreboard_word", 32'(word), 32'(e.word));
    end
  endfunction

  task automatic monitor();
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0;
      end else begin
        if (note_valid && !prev) pop_cmp(K_NOTE, {octave_out, note_out});
        if (done) pop_cmp(K_DONE, '0);
        if (overflow) pop_cmp(K_OVF, '0);
        prev = note_valid;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_note(int idx);
    exp_t e;
    e.kind = K_NOTE;
    e.word = rec_q[idx];
    exp_q.push_back(e);
  endtask

  task automatic push_kind(logic [1:0] k);
    exp_t e;
    e.kind = k;
    e.word = '0;
    exp_q.push_back(e);
  endtask

  task automatic record(logic [3:0] n, logic [1:0] o);
    if (!m_play) begin
      if (rec_q.size() < DEPTH) rec_q.push_back({o, n});
      else push_kind(K_OVF);
    end
    note_data = n;
    octave_data = o;
    ld_note = 1'b1;
    tick();
    ld_note = 1'b0;
    tick();
  endtask

  task automatic start_play();
    bit started;
    started = (rec_q.size() > 0) && !m_play;
    if (started) begin
      m_play = 1'b1;
      ptr = 0;
      push_note(0);
    end
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    tick();
    chk("start_playing", 32'(playing), 32'(m_play));
    chk("start_valid", 32'(note_valid), 32'(m_play));
  endtask

  task automatic step();
    bit was;
    logic [5:0] w;
    was = m_play;
    if (m_play) begin
      if (ptr < rec_q.size() - 1) begin
        ptr++;
        push_note(ptr);
      end else if (loop_en) begin
        ptr = 0;
        push_note(0);
      end else begin
        m_play = 1'b0;
        push_kind(K_DONE);
      end
    end
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    if (was) chk("step_gap_valid", 32'(note_valid), 32'd0);
    tick();
    chk("step_latency_valid", 32'(note_valid), 32'(m_play));
    if (m_play) begin
      w = rec_q[ptr];
      chk("step_note", 32'({octave_out, note_out}), 32'(w));
    end
  endtask

  task automatic stop_play();
    play_stop = 1'b1;
    tick();
    play_stop = 1'b0;
    m_play = 1'b0;
    chk("stop_valid", 32'(note_valid), 32'd0);
    chk("stop_playing", 32'(playing), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rec_q.delete();
    m_play = 1'b0;
    chk("clear_count", 32'(count), 32'd0);
  endtask

  task automatic check_status(string tag);
    chk({tag, "_count"}, 32'(count), 32'(rec_q.size()));
    chk({tag, "_full"}, 32'(full), 32'(rec_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(rec_q.size() == 0));
    chk({tag, "_playing"}, 32'(playing), 32'(m_play));
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_note"}, 32'(note_out), 32'd0);
    chk({tag, "_octave"}, 32'(octave_out), 32'd0);
    chk({tag, "_valid"}, 32'(note_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_playing"}, 32'(playing), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic three-note playback ending in a done pulse.
    record(4'd1, 2'd2);
    record(4'd2, 2'd2);
    record(4'd3, 2'd2);
    check_status("rec3");
    start_play();
    chk("first_note", 32'(note_out), 32'd1);
    chk("first_oct", 32'(octave_out), 32'd2);
    repeat (3) step();
    tick();
    chk("end_idle_playing", 32'(playing), 32'd0);
    chk("end_idle_valid", 32'(note_valid), 32'd0);

    // Fill to DEPTH, then one more record is dropped with an overflow pulse.
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) record(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    check_status("fill");

    // A held ld_note is a single record event.
    do_clear();
    rec_q.push_back({2'd1, 4'd9});
    note_data = 4'd9;
    octave_data = 2'd1;
    ld_note = 1'b1;
    repeat (10) tick();
    ld_note = 1'b0;
    tick();
    check_status("held");

    // Loop over two notes: four steps land back on slot 0, never done.
    do_clear();
    record(4'd7, 2'd1);
    record(4'd12, 2'd3);
    loop_en = 1'b1;
    start_play();
    repeat (4) step();
    chk("loop_slot0_note", 32'(note_out), 32'd7);
    chk("loop_slot0_oct", 32'(octave_out), 32'd1);
    stop_play();
    loop_en = 1'b0;

    // Stop mid-play, restart from slot 0; record attempts during HOLD are ignored.
    record(4'd5, 2'd0);
    start_play();
    step();
    record(4'd15, 2'd3);
    check_status("rec_in_hold");
    stop_play();
    start_play();
    chk("restart_note", 32'(note_out), 32'd7);
    stop_play();

    // Clear beats a coincident step in HOLD; start afterwards is ignored.
    start_play();
    clear = 1'b1;
    step_pulse = 1'b1;
    tick();
    clear = 1'b0;
    step_pulse = 1'b0;
    rec_q.delete();
    m_play = 1'b0;
    chk("clrstep_count", 32'(count), 32'd0);
    chk("clrstep_empty", 32'(empty), 32'd1);
    chk("clrstep_valid", 32'(note_valid), 32'd0);
    chk("clrstep_playing", 32'(playing), 32'd0);
    chk("clrstep_note", 32'(note_out), 32'd0);
    start_play();

    // Asynchronous reset during FETCH clears outputs without a clock edge.
    record(4'd11, 2'd3);
    record(4'd6, 2'd2);
    start_play();
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    chk("prefetch_playing", 32'(playing), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    rec_q.delete();
    m_play = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Randomized record/play rounds.
    for (int r = 0; r < 12; r++) begin
      int k;
      int ns;
      if ($urandom_range(0, 2) == 0) do_clear();
      k = $urandom_range(0, 6);
      for (int j = 0; j < k; j++) record(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      check_status("rand_rec");
      start_play();
      ns = $urandom_range(0, rec_q.size() + 3);
      for (int j = 0; j < ns; j++) begin
        loop_en = 1'($urandom_range(0, 1));
        if (m_play) step();
      end
      if (m_play) stop_play();
      tick();
      check_status("rand_end");
    end

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: number of note slots; power of two, minimum 2.
REQ-002 Parameter NOTE_W, default 4: note-code width.
REQ-003 Parameter OCT_W, default 2: octave-code width.
REQ-004 Derived AW = log2(DEPTH); CW = AW+1.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  synchronous erase of the recorded sequence.
REQ-008 note_data  in  NOTE_W  note to record.
REQ-009 octave_data  in  OCT_W  octave to record.
REQ-010 ld_note  in  1  record request; the rising edge is acted on.
REQ-011 play_start  in  1  start playback (level, sampled in IDLE).
REQ-012 play_stop  in  1  abort playback.
REQ-013 loop_en  in  1  1 = wrap to slot 0 after the last note.
REQ-014 step_pulse  in  1  one-cycle tempo tick; advances playback.
REQ-015 note_out  out  NOTE_W  current playback note.
REQ-016 octave_out  out  OCT_W  current playback octave.
REQ-017 note_valid  out  1  note_out/octave_out hold a live playback note.
REQ-018 count  out  CW  number of recorded notes, 0..DEPTH.
REQ-019 full  out  1  count == DEPTH.
REQ-020 empty  out  1  count == 0.
REQ-021 playing  out  1  state is FETCH or HOLD.
REQ-022 overflow  out  1  one-cycle pulse on a dropped record request.
REQ-023 done  out  1  one-cycle pulse at non-loop end of sequence.

Function
REQ-024 Storage SHALL be a DEPTH x (OCT_W+NOTE_W) register array, word = {octave, note}, with a registered read of 1-cycle latency.
REQ-025 A record event SHALL be ld_note high while the registered ld_note is low; a held ld_note SHALL yield exactly one event.
REQ-026 A record event in IDLE with count<DEPTH SHALL write {octave_data,note_data} to slot count, and count SHALL increment.
REQ-027 A record event in IDLE while full SHALL write nothing, leave count unchanged, and pulse overflow for 1 cycle.
REQ-028 Record events outside IDLE SHALL be ignored, with no overflow pulse.
REQ-029 FSM states SHALL be IDLE, FETCH, HOLD, and DONE.
REQ-030 IDLE: play_start with count>0 SHALL set rd_ptr=0 and go to FETCH; play_start with count==0 SHALL be ignored.
REQ-031 If play_start and a record event occur together in IDLE, play_start SHALL win and the record event SHALL be discarded.
REQ-032 FETCH: the state SHALL last 1 cycle and then go to HOLD; note_valid SHALL be 0 and note_out/octave_out SHALL hold their previous values.
REQ-033 HOLD: note_out/octave_out SHALL equal slot rd_ptr and note_valid SHALL be 1 until step_pulse.
REQ-034 HOLD with step_pulse and rd_ptr<count-1 SHALL increment rd_ptr and go to FETCH.
REQ-035 HOLD with step_pulse and rd_ptr==count-1 SHALL go to FETCH with rd_ptr=0 if loop_en=1, otherwise to DONE.
REQ-036 DONE: the state SHALL last 1 cycle, assert done, and return to IDLE.
REQ-037 Latency from step_pulse in HOLD to the new note_out with note_valid=1 SHALL be 2 cycles.
REQ-038 step_pulse outside HOLD SHALL be ignored.
REQ-039 play_stop in FETCH, HOLD, or DONE SHALL go to IDLE next cycle with note_valid=0 and no done pulse.
REQ-040 clear SHALL set count=0 and state=IDLE, and zero note_out, octave_out, and note_valid; array contents need not be erased.
REQ-041 Priority per cycle SHALL be clear > play_stop > step_pulse.
REQ-042 rd_ptr and the write index SHALL be AW bits wide; count SHALL be CW bits wide and SHALL never exceed DEPTH.

Reset
REQ-043 reset low SHALL asynchronously force IDLE, count=0, rd_ptr=0, registered ld_note=0, and all outputs 0, except empty=1.
REQ-044 Array contents after reset SHALL be don't-care; they are unreachable while count==0.
REQ-045 Reset asserted mid-playback SHALL abort playback with no done pulse.

Verification
REQ-046 Defaults: record notes 1,2,3 at octave 2 -> count=3; play_start -> HOLD with note_out=1 and octave_out=2; each step_pulse gives 2, then 3, 2 cycles after the pulse; the third step_pulse gives a done pulse, then IDLE.
REQ-047 Record 17 events with DEPTH=16 -> count=16, full=1, one overflow pulse; a held ld_note for 10 cycles counts as one event.
REQ-048 loop_en=1 with 2 notes -> after 4 step_pulses note_out is back at slot 0 and done is never asserted.
REQ-049 play_stop while in HOLD -> next cycle IDLE with note_valid=0; a subsequent play_start restarts at slot 0.
REQ-050 Simultaneous clear and step_pulse in HOLD -> count=0, IDLE, note_valid=0; play_start afterwards is ignored.
REQ-051 reset low mid-FETCH -> all outputs 0 immediately with no clock edge required; empty=1.
